// File: rtl/ntru_pkg.sv
// Shared NTRU trit types, constants and FSM state encoding for the trit pack/unpack blocks.
// Define TRIT_SIGNED_EN to emit trits in signed encoding (2 -> 2'b11).
package ntru_pkg;

    localparam int unsigned NTRU_N         = 701;
    localparam int unsigned TRITS_PER_BYTE = 5;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_ZERO = 2'b00;
    localparam trit_t TRIT_ONE  = 2'b01;
    localparam trit_t TRIT_TWO  = 2'b10;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} unpack_state_t;

    // Maps an unsigned mod-3 remainder onto the output trit encoding.
    function automatic trit_t trit_encode(input trit_t r);
`ifdef TRIT_SIGNED_EN
        return (r == TRIT_TWO) ? 2'b11 : r;
`else
        return r;
`endif
    endfunction

endpackage

// File: rtl/bit8_to_trit5_if.sv
// Byte-in / trit-out stream bundle for the base-3 unpacker.
interface bit8_to_trit5_if;
    import ntru_pkg::*;

    logic       start;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    trit_t      trit_out;
    logic       trit_valid;
    logic       trit_ready;
    logic       trit_last;
    logic       done;
    logic       err_range;
    logic       err_pad;

    modport master (
        output start, in_byte, in_valid, trit_ready,
        input  in_ready, trit_out, trit_valid, trit_last, done, err_range, err_pad
    );

    modport slave (
        input  start, in_byte, in_valid, trit_ready,
        output in_ready, trit_out, trit_valid, trit_last, done, err_range, err_pad
    );

endinterface

// File: rtl/div3_u8.sv
// Combinational exact divide-by-3 of an 8-bit value: quotient and remainder.
module div3_u8 (
    input  logic [7:0] b,
    output logic [6:0] q,
    output logic [1:0] r
);

    logic [7:0] q_times3;

    // 171/512 over-approximates 1/3 by less than 1/(3*256), so the floor is exact for b < 256.
    assign q        = 7'(({8'd0, b} * 16'd171) >> 9);
    assign q_times3 = {q, 1'b0} + {1'b0, q};
    assign r        = 2'(b - q_times3);

endmodule

// File: rtl/bit8_to_trit5.sv
// Serial unpacker: each byte carries 5 base-3 trits, emitted one per beat, lowest trit first.
// Optional TRIT_SIGNED_EN (see ntru_pkg) selects signed trit_out encoding.
module bit8_to_trit5
    import ntru_pkg::*;
#(
    parameter int unsigned NUM_TRITS = NTRU_N - 1,
    parameter int unsigned NUM_BYTES = (NUM_TRITS + 4) / 5,
    parameter int unsigned CNT_W     = $clog2(NUM_TRITS + 1)
) (
    input logic             clk,
    input logic             ovr_rst1,
    bit8_to_trit5_if.slave  bus
);

    if (NUM_TRITS == 0 || NUM_BYTES * TRITS_PER_BYTE < NUM_TRITS) begin : g_param_check
        $error("bit8_to_trit5: NUM_BYTES cannot hold NUM_TRITS");
    end

    unpack_state_t    state_q, state_d;
    logic [7:0]       b_q, b_d;
    logic [2:0]       k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_range_q, err_range_d;
    logic             err_pad_q, err_pad_d;

    logic [6:0] q;
    logic [1:0] r;
    logic       is_last;

    div3_u8 u_div3 (
        .b (b_q),
        .q (q),
        .r (r)
    );

    assign is_last = (cnt_q == CNT_W'(NUM_TRITS - 1));

    always_comb begin
        state_d     = state_q;
        b_d         = b_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        err_range_d = err_range_q;
        err_pad_d   = err_pad_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    b_d         = '0;
                    k_d         = '0;
                    cnt_d       = '0;
                    err_range_d = 1'b0;
                    err_pad_d   = 1'b0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    k_d     = '0;
                    state_d = EMIT;
                    if (bus.in_byte >= 8'd243) begin
                        err_range_d = 1'b1;
                        b_d         = '0;
                    end else begin
                        b_d = bus.in_byte;
                    end
                end
            end
            EMIT: begin
                if (bus.trit_ready) begin
                    b_d   = {1'b0, q};
                    k_d   = k_q + 3'd1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_last) begin
                        // Trits above the frame end must be zero in a well-formed final byte.
                        if (q != '0) begin
                            err_pad_d = 1'b1;
                        end
                        state_d = DONE;
                    end else if (k_q == 3'(TRITS_PER_BYTE - 1)) begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge ovr_rst1) begin
        if (ovr_rst1) begin
            state_q     <= IDLE;
            b_q         <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            err_range_q <= 1'b0;
            err_pad_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            err_range_q <= err_range_d;
            err_pad_q   <= err_pad_d;
        end
    end

    assign bus.in_ready   = (state_q == LOAD);
    assign bus.trit_valid = (state_q == EMIT);
    assign bus.trit_out   = (state_q == EMIT) ? trit_encode(r) : TRIT_ZERO;
    assign bus.trit_last  = (state_q == EMIT) && is_last;
    assign bus.done       = (state_q == DONE);
    assign bus.err_range  = err_range_q;
    assign bus.err_pad    = err_pad_q;

endmodule

// File: tb/tb_bit8_to_trit5.sv
// Self-checking bench for bit8_to_trit5: three instances (5, 7 and 700 trits) on shared stimulus.
module tb_bit8_to_trit5;

    logic       clk = 1'b0;
    logic       ovr_rst1 = 1'b0;
    logic [7:0] in_byte = '0;
    logic       in_valid = 1'b0;
    logic       trit_ready = 1'b0;
    logic [2:0] start_v = '0;
    int         sel = 0;

    int assertions = 0;
    int failures = 0;

    int         sb[$];
    logic [7:0] tb_bytes[$];
    int         tb_trits[$];
    int         first_acc, first_val, done_at;

    always #5 clk = ~clk;

    bit8_to_trit5_if bus5 ();
    bit8_to_trit5_if bus7 ();
    bit8_to_trit5_if bus700 ();

    assign bus5.start        = start_v[0];
    assign bus5.in_byte      = in_byte;
    assign bus5.in_valid     = in_valid;
    assign bus5.trit_ready   = trit_ready;
    assign bus7.start        = start_v[1];
    assign bus7.in_byte      = in_byte;
    assign bus7.in_valid     = in_valid;
    assign bus7.trit_ready   = trit_ready;
    assign bus700.start      = start_v[2];
    assign bus700.in_byte    = in_byte;
    assign bus700.in_valid   = in_valid;
    assign bus700.trit_ready = trit_ready;

    bit8_to_trit5 #(.NUM_TRITS(5)) dut5 (.clk(clk), .ovr_rst1(ovr_rst1), .bus(bus5.slave));
    bit8_to_trit5 #(.NUM_TRITS(7)) dut7 (.clk(clk), .ovr_rst1(ovr_rst1), .bus(bus7.slave));
    bit8_to_trit5 dut700 (.clk(clk), .ovr_rst1(ovr_rst1), .bus(bus700.slave));

    // {in_ready, trit_out[1:0], trit_valid, trit_last, done, err_range, err_pad}
    logic [7:0] obs[3];
    logic [7:0] cur;
    assign obs[0] = {bus5.in_ready, bus5.trit_out, bus5.trit_valid, bus5.trit_last,
                     bus5.done, bus5.err_range, bus5.err_pad};
    assign obs[1] = {bus7.in_ready, bus7.trit_out, bus7.trit_valid, bus7.trit_last,
                     bus7.done, bus7.err_range, bus7.err_pad};
    assign obs[2] = {bus700.in_ready, bus700.trit_out, bus700.trit_valid, bus700.trit_last,
                     bus700.done, bus700.err_range, bus700.err_pad};
    assign cur = obs[sel];

    function automatic logic [1:0] enc(input int t);
`ifdef TRIT_SIGNED_EN
        return (t == 2) ? 2'b11 : 2'(t);
`else
        return 2'(t);
`endif
    endfunction

    // Runs one frame on instance s from tb_bytes; expected trits come from tb_trits.
    task automatic drive_frame(input int s, input bit gaps, input int stall_at);
        int bi, ti, stall, n, cyc;
        logic [1:0] held;
        n = tb_trits.size();
        sel = s;
        sb.delete();
        bi = 0; ti = 0; stall = 0; held = '0;
        first_acc = -1; first_val = -1;
        @(negedge clk);
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        for (cyc = 0; cyc < 4000 && cur[2] !== 1'b1; cyc++) begin
            in_valid   = (bi < tb_bytes.size()) && (!gaps || $urandom_range(0, 3) != 0);
            in_byte    = in_valid ? tb_bytes[bi] : 8'($urandom);
            trit_ready = !gaps || $urandom_range(0, 2) != 0;
            if (cur[4] === 1'b1 && first_val < 0) first_val = cyc;
            if (stall_at == ti && stall < 3 && cur[4] === 1'b1) begin
                trit_ready = 1'b0;
                if (stall == 0) held = cur[6:5];
                assertions++;
                if ((stall > 0 && cur[6:5] !== held) || cur[7] !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_hold: trit_out=%0d in_ready=%0b, required %0d and 0",
                             cur[6:5], cur[7], held);
                end
                stall++;
            end
            if (in_valid && cur[7] === 1'b1) begin
                for (int j = 5 * bi; j < 5 * bi + 5 && j < n; j++) sb.push_back(tb_trits[j]);
                if (first_acc < 0) first_acc = cyc;
                bi++;
            end
            if (cur[4] === 1'b1 && trit_ready) begin
                assertions++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL trit_extra: trit %0d emitted with nothing expected", ti);
                end else begin
                    int t;
                    t = sb.pop_front();
                    if (cur[6:5] !== enc(t) || cur[3] !== (ti == n - 1)) begin
                        failures++;
                        $display("FAIL trit[%0d]: got %0d last=%0b, required %0d last=%0b",
                                 ti, cur[6:5], cur[3], enc(t), ti == n - 1);
                    end
                end
                ti++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        trit_ready = 1'b0;
        done_at = cyc;
        assertions++;
        if (cur[2] !== 1'b1 || ti != n || sb.size() != 0) begin
            failures++;
            $display("FAIL frame_end: done=%0b trits=%0d left=%0d, required done=1 trits=%0d left=0",
                     cur[2], ti, sb.size(), n);
        end
    endtask

    task automatic test_reset();
        #2 ovr_rst1 = 1'b1;
        #3;
        for (int s = 0; s < 3; s++) begin
            assertions++;
            if (obs[s] !== 8'h00) begin
                failures++;
                $display("FAIL reset_asserted[%0d]: outputs=%h, required 00", s, obs[s]);
            end
        end
        @(negedge clk);
        ovr_rst1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            assertions++;
            if (obs[s] !== 8'h00) begin
                failures++;
                $display("FAIL reset_released[%0d]: outputs=%h, required 00", s, obs[s]);
            end
        end
    endtask

    task automatic test_all_twos();
        tb_bytes = '{8'd242};
        tb_trits = '{2, 2, 2, 2, 2};
        drive_frame(0, 1'b0, -1);
        assertions++;
        if (cur[1:0] !== 2'b00 || done_at - first_acc != 6) begin
            failures++;
            $display("FAIL all_twos: errs=%b cycles=%0d, required errs=00 cycles=6",
                     cur[1:0], done_at - first_acc);
        end
    endtask

    task automatic test_latency();
        tb_bytes = '{8'd100};
        tb_trits = '{1, 0, 2, 0, 1};
        drive_frame(0, 1'b0, -1);
        assertions++;
        if (first_val - first_acc != 1 || done_at - first_acc != 6) begin
            failures++;
            $display("FAIL latency: first_valid=%0d total=%0d, required 1 and 6",
                     first_val - first_acc, done_at - first_acc);
        end
    endtask

    task automatic test_backpressure();
        tb_bytes = '{8'd100};
        tb_trits = '{1, 0, 2, 0, 1};
        drive_frame(0, 1'b0, 2);
        assertions++;
        if (done_at - first_acc != 9) begin
            failures++;
            $display("FAIL backpressure_cycles: got %0d, required 9", done_at - first_acc);
        end
    endtask

    task automatic test_range();
        tb_bytes = '{8'd243};
        tb_trits = '{0, 0, 0, 0, 0};
        drive_frame(0, 1'b0, -1);
        assertions++;
        if (cur[1:0] !== 2'b10) begin
            failures++;
            $display("FAIL range_set: errs=%b, required 10", cur[1:0]);
        end
        tb_bytes = '{8'd100};
        tb_trits = '{1, 0, 2, 0, 1};
        drive_frame(0, 1'b0, -1);
        assertions++;
        if (cur[1] !== 1'b0) begin
            failures++;
            $display("FAIL range_cleared: err_range=%b, required 0", cur[1]);
        end
    endtask

    task automatic test_pad();
        tb_trits = '{1, 0, 2, 0, 1, 1, 1};
        tb_bytes = '{8'd100, 8'd4};
        drive_frame(1, 1'b0, -1);
        assertions++;
        if (cur[1:0] !== 2'b00) begin
            failures++;
            $display("FAIL pad_clean: errs=%b, required 00", cur[1:0]);
        end
        tb_bytes = '{8'd100, 8'd13};
        drive_frame(1, 1'b1, -1);
        assertions++;
        if (cur[1:0] !== 2'b01) begin
            failures++;
            $display("FAIL pad_dirty: errs=%b, required 01", cur[1:0]);
        end
    endtask

    // Packer model: byte = t0 + 3*t1 + 9*t2 + 27*t3 + 81*t4, zero-padded past the frame.
    task automatic make_random_frame();
        tb_trits.delete();
        tb_bytes.delete();
        for (int i = 0; i < 700; i++) tb_trits.push_back(int'($urandom_range(0, 2)));
        for (int i = 0; i < 140; i++) begin
            int v;
            v = 0;
            for (int j = 4; j >= 0; j--) v = v * 3 + ((5 * i + j < 700) ? tb_trits[5 * i + j] : 0);
            tb_bytes.push_back(8'(v));
        end
    endtask

    task automatic test_random_frame();
        make_random_frame();
        drive_frame(2, 1'b1, -1);
        assertions++;
        if (cur[1:0] !== 2'b00) begin
            failures++;
            $display("FAIL random_errs: errs=%b, required 00", cur[1:0]);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        sel = 2;
        @(negedge clk);
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        in_valid = 1'b1;
        in_byte = 8'd100;
        trit_ready = 1'b1;
        for (w = 0; w < 20 && !(cur[4] === 1'b1 && cur[6:5] === enc(2)); w++) @(negedge clk);
        in_valid = 1'b0;
        ovr_rst1 = 1'b1;
        #1;
        assertions++;
        if (w >= 20 || obs[2] !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid: outputs=%h waited=%0d, required 00 within 20", obs[2], w);
        end
        @(negedge clk);
        ovr_rst1 = 1'b0;
        make_random_frame();
        drive_frame(2, 1'b1, -1);
    endtask

    initial begin
        test_reset();
        test_all_twos();
        test_latency();
        test_backpressure();
        test_range();
        test_pad();
        test_random_frame();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
